sha_block_planner: RTL and testbench
====================================

# sha_block_planner

Parametrised message-block planner for the SHA front end. It accepts a message length in bytes and a digest mode (SHA-256 or SHA-512 framing). It registers the padded block count, then streams one descriptor per block through a valid/ready handshake. Each descriptor tells the message-schedule loader how many message bytes the block holds, where the 0x80 pad marker goes, and whether the block carries the length field.

## Interface

- LEN_W, 32: width of the message length in bytes.
- NB_W, 16: width of block count and block index; counts above 2^NB_W-1 are an error.

- clk  in  1: clock, all state on rising edge.
- reset_n  in  1: asynchronous active-low reset.
- req_valid  in  1: request present.
- req_ready  out  1: high only in IDLE.
- req_size  in  LEN_W: message length, bytes.
- req_mode  in  1: 0 = 64-byte blocks, 8-byte length field (threshold 56); 1 = 128-byte blocks, 16-byte length field (threshold 112).
- num_blocks  out  NB_W: padded block count of the current request.
- plan_err  out  1: one-cycle pulse; the count overflowed NB_W.
- blk_valid  out  1: descriptor valid.
- blk_ready  in  1: consumer accepts descriptor.
- blk_idx  out  NB_W: block index, 0-based.
- blk_data_bytes  out  8: message bytes in this block, 0..BS.
- blk_pad_here  out  1: 0x80 marker lies in this block.
- blk_pad_pos  out  7: byte offset of the marker; 0 when blk_pad_here=0.
- blk_last  out  1: final block; carries the length field.

## Operation

- BS is 64 (mode 0) or 128 (mode 1). TH is BS-8 or BS-16 respectively. req_size and req_mode are latched on accept (req_valid & req_ready).
- Count rule, in LEN_W-bit arithmetic: q = size >> log2(BS), r = size mod BS, n = q + (r < TH ? 1 : 2). If n > 2^NB_W-1, the request is an overflow.
- FSM states: IDLE, CALC, EMIT, ERR.
  - IDLE: req_ready=1. Accept -> CALC.
  - CALC: one cycle. Register n into num_blocks (low NB_W bits) and zero the block index. Go to ERR on overflow, else to EMIT.
  - EMIT: blk_valid=1. On blk_valid & blk_ready: if blk_last, go to IDLE; else increment the index.
  - ERR: one cycle with plan_err=1, num_blocks=0, no descriptors, then IDLE.
- Descriptor for block k:
  - blk_data_bytes = BS if k < q; r if k == q; 0 if k > q.
  - blk_pad_here = (k == q).
  - blk_pad_pos = r when blk_pad_here=1.
  - blk_last = (k == n-1).
- Boundary cases:
  - When r >= TH, the marker lands in block n-2 and the last block has 0 data bytes.
  - When r == 0 and size > 0, the marker is at pos 0 of block q.
  - size = 0 gives n=1: data 0, pad pos 0, last.
- Descriptor fields are registered and change only on a handshake or on a state transition.
- num_blocks holds from the end of CALC until the next CALC.
- reset_n low at any time, including mid-EMIT, clears everything immediately. The block returns to IDLE and the partial plan is discarded.

## Timing

- Reset values: req_ready=1 once reset is released. All other outputs are 0: num_blocks, plan_err, blk_valid, blk_idx, blk_data_bytes, blk_pad_here, blk_pad_pos, blk_last.
- Accept at cycle t; CALC runs in cycle t+1.
- num_blocks is valid from t+2. blk_valid also rises at t+2, or plan_err pulses at t+2 instead.
- Throughput is 1 descriptor per cycle while blk_ready=1.
- With blk_ready low, blk_valid stays high and all descriptor fields are held stable.
- The final handshake at cycle u returns the block to IDLE in u+1; req_ready is high in u+1.
- A new request cannot be accepted in the same cycle as the last handshake.

## Test plan

- Mode 0, size=55 -> num_blocks=1; one descriptor: idx0, data 55, pad_here=1, pos 55, last=1.
- Mode 0, size=56 -> num_blocks=2:
  - idx0: data 56, pad pos 56, last=0.
  - idx1: data 0, pad_here=0, last=1.
- Mode 0, size=64 -> num_blocks=2. idx0: data 64, pad_here=0. idx1: data 0, pad pos 0, last=1.
- Mode 1, size=111 -> num_blocks=1, pad pos 111. Mode 1, size=112 -> num_blocks=2, last block data 0.
- Mode 0, size=0x0040_0000 -> n=65537 overflows NB_W=16. Required: plan_err pulses 1 cycle at t+2, num_blocks=0, no blk_valid, req_ready back high at t+3.
- Mode 0, size=200 (n=4):
  - Hold blk_ready low 5 cycles on idx1: fields stay stable.
  - Assert reset_n low mid-stream: all outputs clear.
  - After release, req_ready=1, and a fresh request of size=0 yields one descriptor: data 0, pos 0, last=1.

Source files
------------

// File: rtl/sha_block_planner_if.sv
// Request and descriptor bus of the SHA block planner.
// The master side issues requests and consumes descriptors. The slave side is the planner.
interface sha_block_planner_if #(
    parameter int LEN_W = 32,
    parameter int NB_W  = 16
) ();
    logic             req_valid;
    logic             req_ready;
    logic [LEN_W-1:0] req_size;
    logic             req_mode;
    logic [NB_W-1:0]  num_blocks;
    logic             plan_err;
    logic             blk_valid;
    logic             blk_ready;
    logic [NB_W-1:0]  blk_idx;
    logic [7:0]       blk_data_bytes;
    logic             blk_pad_here;
    logic [6:0]       blk_pad_pos;
    logic             blk_last;

    modport master (
        output req_valid, req_size, req_mode, blk_ready,
        input  req_ready, num_blocks, plan_err, blk_valid, blk_idx,
               blk_data_bytes, blk_pad_here, blk_pad_pos, blk_last
    );

    modport slave (
        input  req_valid, req_size, req_mode, blk_ready,
        output req_ready, num_blocks, plan_err, blk_valid, blk_idx,
               blk_data_bytes, blk_pad_here, blk_pad_pos, blk_last
    );
endinterface

// File: rtl/sha_block_planner.sv
// Plans SHA-256/512 padded message blocks and streams one descriptor per block.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
module sha_block_planner #(
    parameter int LEN_W = 32,
    parameter int NB_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sha_block_planner_if.slave   bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_ERR} state_t;

    localparam logic [LEN_W-1:0] NB_MAX = {{(LEN_W-NB_W){1'b0}}, {NB_W{1'b1}}};

    state_t           state, state_nx;
    logic [LEN_W-1:0] size_q;
    logic             mode_q;
    logic [LEN_W-1:0] qb_q;
    logic [6:0]       r_q;
    logic [NB_W-1:0]  nblk_q;
    logic [NB_W-1:0]  idx_q;
    logic [7:0]       data_q;
    logic             here_q;
    logic [6:0]       pos_q;
    logic             last_q;

    logic [LEN_W-1:0] q_calc, n_calc;
    logic [6:0]       r_calc, th;
    logic             ovf;

    logic             in_calc, fire;
    logic [NB_W-1:0]  k_sel, n_sel;
    logic [LEN_W-1:0] q_sel, kx;
    logic [6:0]       r_sel;
    logic [7:0]       d_data;
    logic             d_here, d_last;
    logic [6:0]       d_pos;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.req_valid)         state_nx = S_CALC;
            S_CALC: state_nx = ovf ? S_ERR : S_EMIT;
            S_EMIT: if (bus.blk_ready && last_q) state_nx = S_IDLE;
            S_ERR:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.req_ready = 1'b0;
        bus.blk_valid = 1'b0;
        bus.plan_err  = 1'b0;
        case (state)
            S_IDLE: bus.req_ready = 1'b1;
            S_EMIT: bus.blk_valid = 1'b1;
            S_ERR:  bus.plan_err  = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

    // Block count from the latched request
    always_comb begin
        q_calc = mode_q ? (size_q >> 7) : (size_q >> 6);
        r_calc = mode_q ? size_q[6:0] : {1'b0, size_q[5:0]};
        th     = mode_q ? 7'd112 : 7'd56;
        n_calc = q_calc + ((r_calc < th) ? LEN_W'(1) : LEN_W'(2));
        ovf    = (n_calc > NB_MAX);
    end

    // Descriptor of the block about to be presented: block 0 in CALC, idx+1 after a handshake
    always_comb begin
        in_calc = (state == S_CALC);
        fire    = (state == S_EMIT) && bus.blk_ready;
        k_sel   = in_calc ? '0 : idx_q + 1'b1;
        q_sel   = in_calc ? q_calc : qb_q;
        r_sel   = in_calc ? r_calc : r_q;
        n_sel   = in_calc ? n_calc[NB_W-1:0] : nblk_q;
        kx      = {{(LEN_W-NB_W){1'b0}}, k_sel};
        d_here  = (kx == q_sel);
        if (kx < q_sel)  d_data = mode_q ? 8'd128 : 8'd64;
        else if (d_here) d_data = {1'b0, r_sel};
        else             d_data = 8'd0;
        d_pos   = d_here ? r_sel : 7'd0;
        d_last  = (k_sel == n_sel - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            size_q <= '0;
            mode_q <= 1'b0;
            qb_q   <= '0;
            r_q    <= '0;
            nblk_q <= '0;
            idx_q  <= '0;
            data_q <= '0;
            here_q <= 1'b0;
            pos_q  <= '0;
            last_q <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.req_valid) begin
                size_q <= bus.req_size;
                mode_q <= bus.req_mode;
            end
            if (in_calc) begin
                qb_q   <= q_calc;
                r_q    <= r_calc;
                nblk_q <= ovf ? '0 : n_calc[NB_W-1:0];
                idx_q  <= '0;
                data_q <= ovf ? 8'd0 : d_data;
                here_q <= ovf ? 1'b0 : d_here;
                pos_q  <= ovf ? 7'd0 : d_pos;
                last_q <= ovf ? 1'b0 : d_last;
            end else if (fire && !last_q) begin
                idx_q  <= k_sel;
                data_q <= d_data;
                here_q <= d_here;
                pos_q  <= d_pos;
                last_q <= d_last;
            end
        end
    end

    assign bus.num_blocks     = nblk_q;
    assign bus.blk_idx        = idx_q;
    assign bus.blk_data_bytes = data_q;
    assign bus.blk_pad_here   = here_q;
    assign bus.blk_pad_pos    = pos_q;
    assign bus.blk_last       = last_q;
endmodule

// File: tb/tb_sha_block_planner.sv
// Self-checking bench for sha_block_planner.
// Descriptors are predicted from padded-length arithmetic and compared as the planner emits them.
module tb_sha_block_planner;
  logic clk;
  logic reset_n;
  logic [1:0] state_dbg;

  sha_block_planner_if #(.LEN_W(32), .NB_W(16)) bus ();

  sha_block_planner #(.LEN_W(32), .NB_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] cur_desc();
    return {bus.blk_idx, bus.blk_data_bytes, bus.blk_pad_here, bus.blk_pad_pos, bus.blk_last};
  endfunction

  // scoreboard: compare each accepted descriptor with the queue head
  always @(negedge clk) begin
    if (reset_n && bus.blk_valid && bus.blk_ready) begin
      if (exp_q.size() == 0) chk("unexpected_blk", 64'(cur_desc()), 64'h1_ffff_ffff);
      else chk("blk_desc", 64'(cur_desc()), 64'(exp_q.pop_front()));
    end
  end

  // padded length rounded up to whole blocks, marker at byte offset size
  function automatic longint model_n(input logic [31:0] size, input logic mode);
    longint bs = mode ? 128 : 64;
    longint lf = mode ? 16 : 8;
    return (longint'(size) + 1 + lf + bs - 1) / bs;
  endfunction

  task automatic push_plan(input logic [31:0] size, input logic mode);
    longint bs = mode ? 128 : 64;
    longint n = model_n(size, mode);
    longint sz = longint'(size);
    for (longint k = 0; k < n; k++) begin
      longint st = k * bs;
      logic [7:0] d;
      logic here;
      logic [6:0] pos;
      if (sz >= st + bs) d = 8'(bs);
      else if (sz > st) d = 8'(sz - st);
      else d = 8'd0;
      here = ((sz / bs) == k);
      pos = here ? 7'(sz % bs) : 7'd0;
      exp_q.push_back({16'(k), d, here, pos, (k == n - 1)});
    end
  endtask

  // driver: issue one request, check timing, drain descriptors
  task automatic do_req(input logic [31:0] size, input logic mode, input bit rnd);
    longint n = model_n(size, mode);
    bit ovf = (n > 65535);
    int cyc = 0;
    if (!ovf) push_plan(size, mode);
    @(posedge clk); #1;
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_size = size;
    bus.req_mode = mode;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("req_ready_calc", bus.req_ready, 0);
    chk("blk_valid_calc", bus.blk_valid, 0);
    @(posedge clk); #1;
    if (ovf) begin
      chk("err_pulse", bus.plan_err, 1);
      chk("err_num_blocks", bus.num_blocks, 0);
      chk("err_blk_valid", bus.blk_valid, 0);
      @(posedge clk); #1;
      chk("err_pulse_end", bus.plan_err, 0);
      chk("err_blk_valid2", bus.blk_valid, 0);
      chk("err_req_ready", bus.req_ready, 1);
    end else begin
      chk("num_blocks", bus.num_blocks, 64'(n));
      chk("blk_valid_rise", bus.blk_valid, 1);
      chk("plan_err_quiet", bus.plan_err, 0);
      while (exp_q.size() > 0 && cyc < 3000) begin
        bus.blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 0);
      chk("done_req_ready", bus.req_ready, 1);
      chk("done_blk_valid", bus.blk_valid, 0);
      chk("num_blocks_hold", bus.num_blocks, 64'(n));
      bus.blk_ready = 1'b1;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_num_blocks"}, bus.num_blocks, 0);
    chk({tag, "_plan_err"}, bus.plan_err, 0);
    chk({tag, "_blk_valid"}, bus.blk_valid, 0);
    chk({tag, "_desc"}, 64'(cur_desc()), 0);
  endtask

  initial begin
    logic [32:0] snap;
    bus.req_valid = 1'b0;
    bus.req_size = '0;
    bus.req_mode = 1'b0;
    bus.blk_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", bus.req_ready, 1);

    // directed boundaries
    do_req(32'd55, 1'b0, 0);
    do_req(32'd56, 1'b0, 0);
    do_req(32'd64, 1'b0, 0);
    do_req(32'd111, 1'b1, 0);
    do_req(32'd112, 1'b1, 0);
    do_req(32'd128, 1'b1, 1);
    do_req(32'd0, 1'b1, 0);
    do_req(32'h0040_0000, 1'b0, 0);
    do_req(32'd300, 1'b0, 1);

    // random lengths and modes with random back-pressure
    for (int i = 0; i < 8; i++)
      do_req(32'($urandom_range(0, 700)), 1'($urandom_range(0, 1)), 1);

    // stall on idx1 then reset mid-stream
    push_plan(32'd200, 1'b0);
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_size = 32'd200;
    bus.req_mode = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall_num_blocks", bus.num_blocks, 4);
    @(posedge clk); #1;
    bus.blk_ready = 1'b0;
    snap = cur_desc();
    chk("stall_idx", bus.blk_idx, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", bus.blk_valid, 1);
      chk("stall_desc", 64'(cur_desc()), 64'(snap));
    end
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk_outputs_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", bus.req_ready, 1);
    do_req(32'd0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
